des3_round_sequencer: RTL and testbench

Parametrised successor to the DES controller: accepts 64-bit blocks tagged with direction and channel into an input FIFO, then sequences each block through PASSES × ROUNDS Feistel rounds using an external combinational round function, with EDE/DED key ordering. It owns the L/R state, the counters and the buffering. Upstream and downstream IP/FP permutation wrappers, the key schedule and the f-function sit outside this block. It sits between the host block interface and the existing round core.

---
 rtl/des3_round_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_des3_round_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des3_round_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : des3_round_sequencer
// Purpose  : Buffers IP-permuted 64-bit blocks (with direction and channel
//            tag) in a small FIFO. Each block is run through PASSES x ROUNDS
//            Feistel rounds using an external combinational f-function.
//            Keys are ordered EDE for encrypt and DED for decrypt.
// Ports    : clk, n_rst (async, active-low), clear (sync flush)
//            in_valid/in_ready/in_data/in_dec/in_tag    - block input
//            out_valid/out_ready/out_data/out_dec/out_tag - result output
//            rnd_r/rnd_key_sel/rnd_sub_idx -> f-function, rnd_f <- f result
//            busy, fifo_count                            - status
// Revision : 1.0  initial release
// ============================================================================
module des3_round_sequencer #(
    parameter int ROUNDS = 16,
    parameter int PASSES = 3,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 2
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [63:0]                in_data,
    input  logic                       in_dec,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_data,
    output logic                       out_dec,
    output logic [TAG_W-1:0]           out_tag,
    output logic [31:0]                rnd_r,
    output logic [1:0]                 rnd_key_sel,
    output logic [3:0]                 rnd_sub_idx,
    input  logic [31:0]                rnd_f,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int c_EW = 64 + 1 + TAG_W;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_HOLD = 2'd2;

    // ------------------------------------------------------------------------
    // Input FIFO: entry = {data, dec, tag}
    // ------------------------------------------------------------------------
    logic [c_EW-1:0] r_mem [0:DEPTH-1];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    // Engine state
    logic [1:0]       r_state;
    logic [31:0]      r_l;
    logic [31:0]      r_r;
    logic [c_PW-1:0]  r_pass;
    logic [3:0]       r_rnd;
    logic             r_dec;
    logic [TAG_W-1:0] r_tag;

    // Output register
    logic             r_out_valid;
    logic [63:0]      r_out_data;
    logic             r_out_dec;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_full;
    logic             w_empty;
    logic             w_out_free;
    logic             w_push;
    logic             w_pop;
    logic [c_EW-1:0]  w_head;
    logic [31:0]      w_new_l;
    logic [31:0]      w_new_r;
    logic             w_last_rnd;
    logic             w_last_pass;
    logic [c_PW-1:0]  w_key_pass;
    logic             w_dir_e;
    logic [3:0]       w_sub;
    logic             w_run;

    assign w_full     = (r_count == c_CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    // Full blocks a push even when a pop happens on the same edge.
    assign in_ready   = !w_full;
    assign w_out_free = !r_out_valid || out_ready;
    assign w_push     = in_valid && !w_full && !clear;
    assign w_pop      = (r_state == c_S_IDLE) && !w_empty && w_out_free && !clear;
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_data, in_dec, in_tag};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_AW'(DEPTH - 1)) ? '0 : r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_AW'(DEPTH - 1)) ? '0 : r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Round datapath and key ordering
    // ------------------------------------------------------------------------
    assign w_run       = (r_state == c_S_RUN);
    assign w_new_l     = r_r;
    assign w_new_r     = r_l ^ rnd_f;
    assign w_last_rnd  = (r_rnd == 4'(ROUNDS - 1));
    assign w_last_pass = (r_pass == c_PW'(PASSES - 1));

    // Decrypt walks the key banks backwards; the pass direction alternates
    // starting with E for encrypt and D for decrypt.
    assign w_key_pass  = r_dec ? (c_PW'(PASSES - 1) - r_pass) : r_pass;
    assign w_dir_e     = ~(r_dec ^ r_pass[0]);
    assign w_sub       = w_dir_e ? r_rnd : (4'(ROUNDS - 1) - r_rnd);

    assign rnd_r       = w_run ? r_r : 32'd0;
    assign rnd_key_sel = w_run ? 2'(w_key_pass) : 2'd0;
    assign rnd_sub_idx = w_run ? w_sub : 4'd0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= c_S_IDLE;
            r_l         <= '0;
            r_r         <= '0;
            r_pass      <= '0;
            r_rnd       <= '0;
            r_dec       <= 1'b0;
            r_tag       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_dec   <= 1'b0;
            r_out_tag   <= '0;
        end else if (clear) begin
            r_state     <= c_S_IDLE;
            r_pass      <= '0;
            r_rnd       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Consumer handshake; a load later in this block overrides it.
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                c_S_IDLE: begin
                    if (w_pop) begin
                        r_l     <= w_head[c_EW-1 -: 32];
                        r_r     <= w_head[c_EW-33 -: 32];
                        r_dec   <= w_head[TAG_W];
                        r_tag   <= w_head[TAG_W-1:0];
                        r_pass  <= '0;
                        r_rnd   <= '0;
                        r_state <= c_S_RUN;
                    end
                end
                c_S_RUN: begin
                    if (!w_last_rnd) begin
                        r_l   <= w_new_l;
                        r_r   <= w_new_r;
                        r_rnd <= r_rnd + 4'd1;
                    end else begin
                        // End of pass: the final swap feeds the next pass.
                        r_rnd <= '0;
                        if (!w_last_pass) begin
                            r_l    <= w_new_r;
                            r_r    <= w_new_l;
                            r_pass <= r_pass + c_PW'(1);
                        end else if (w_out_free) begin
                            r_out_data  <= {w_new_r, w_new_l};
                            r_out_dec   <= r_dec;
                            r_out_tag   <= r_tag;
                            r_out_valid <= 1'b1;
                            r_pass      <= '0;
                            r_state     <= c_S_IDLE;
                        end else begin
                            r_l     <= w_new_r;
                            r_r     <= w_new_l;
                            r_pass  <= '0;
                            r_state <= c_S_HOLD;
                        end
                    end
                end
                c_S_HOLD: begin
                    if (out_ready) begin
                        r_out_data  <= {r_l, r_r};
                        r_out_dec   <= r_dec;
                        r_out_tag   <= r_tag;
                        r_out_valid <= 1'b1;
                        r_state     <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_dec    = r_out_dec;
    assign out_tag    = r_out_tag;
    assign busy       = (r_state != c_S_IDLE);
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_des3_round_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_des3_round_sequencer
// Purpose  : Self-checking bench for des3_round_sequencer (3-pass unit plus a
//            single-pass unit). Results are predicted by a behavioural Feistel
//            model driven by the same stand-in f-function.
// Revision : 1.0  initial release
// ============================================================================
module tb_des3_round_sequencer;

    localparam int ROUNDS = 16;
    localparam int PASSES = 3;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             n_rst, clear, in_valid, in_ready, in_dec, out_valid, out_ready, out_dec, busy;
    logic [63:0]      in_data, out_data;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [31:0]      rnd_r, rnd_f;
    logic [1:0]       rnd_key_sel;
    logic [3:0]       rnd_sub_idx;
    logic [2:0]       fifo_count;
    logic             stub_zero;

    logic             in_valid1, in_ready1, in_dec1, out_valid1, out_dec1, busy1;
    logic [63:0]      in_data1, out_data1;
    logic [TAG_W-1:0] in_tag1, out_tag1;
    logic [31:0]      rnd_r1, rnd_f1;
    logic [1:0]       rnd_key_sel1;
    logic [3:0]       rnd_sub_idx1;
    logic [2:0]       fifo_count1;

    // Stand-in f-function: any mixing of (R, key bank, subkey index) will do.
    function automatic logic [31:0] fmod(input logic [31:0] r, input int ks, input int si);
        logic [31:0] k;
        k = 32'h9e3779b9 * 32'(ks * 16 + si + 1);
        return ({r[24:0], r[31:25]} + k) ^ (r >> 3) ^ 32'h0f1e2d3c;
    endfunction

    assign rnd_f  = stub_zero ? 32'd0 : fmod(rnd_r, int'(rnd_key_sel), int'(rnd_sub_idx));
    assign rnd_f1 = fmod(rnd_r1, int'(rnd_key_sel1), int'(rnd_sub_idx1));

    des3_round_sequencer #(.ROUNDS(ROUNDS), .PASSES(PASSES), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .n_rst(n_rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dec(in_dec), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dec(out_dec), .out_tag(out_tag),
        .rnd_r(rnd_r), .rnd_key_sel(rnd_key_sel), .rnd_sub_idx(rnd_sub_idx), .rnd_f(rnd_f),
        .busy(busy), .fifo_count(fifo_count)
    );

    des3_round_sequencer #(.ROUNDS(16), .PASSES(1), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .clear(1'b0),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_dec(in_dec1), .in_tag(in_tag1),
        .out_valid(out_valid1), .out_ready(1'b1), .out_data(out_data1), .out_dec(out_dec1), .out_tag(out_tag1),
        .rnd_r(rnd_r1), .rnd_key_sel(rnd_key_sel1), .rnd_sub_idx(rnd_sub_idx1), .rnd_f(rnd_f1),
        .busy(busy1), .fifo_count(fifo_count1)
    );

    // Behavioural reference: straight Feistel rounds, swap after every pass.
    function automatic logic [63:0] ref_block(input logic [63:0] d, input logic dec,
                                              input int passes, input int rounds, input logic zero);
        logic [31:0] l, r, t;
        int key, sub;
        logic dir_e;
        l = d[63:32];
        r = d[31:0];
        for (int p = 0; p < passes; p++) begin
            key   = dec ? passes - 1 - p : p;
            dir_e = ((p % 2) == 0) ^ dec;
            for (int k = 0; k < rounds; k++) begin
                sub = dir_e ? k : rounds - 1 - k;
                t   = zero ? l : (l ^ fmod(r, key, sub));
                l   = r;
                r   = t;
            end
            t = l; l = r; r = t;
        end
        return {l, r};
    endfunction

    typedef struct {
        logic [63:0]      d;
        logic             dec;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        sb[$];
    int          out_times[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        rand_ready = 1'b0;
    logic [63:0] last_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: book the handshakes that the coming edge will perform.
    task automatic tick();
        exp_t e;
        if (rand_ready) out_ready = 1'($urandom);
        if (in_valid && in_ready && !clear) begin
            e.d   = ref_block(in_data, in_dec, PASSES, ROUNDS, stub_zero);
            e.dec = in_dec;
            e.tag = in_tag;
            sb.push_back(e);
        end
        if (out_valid && out_ready && !clear) begin
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_data", out_data, e.d);
                chk("sb_meta", 64'({out_dec, out_tag}), 64'({e.dec, e.tag}));
            end
            last_out = out_data;
            out_times.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic push(input logic [63:0] d, input logic dec, input logic [TAG_W-1:0] tag);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_dec = dec; in_tag = tag;
        while (!in_ready && n < 400) begin tick(); n++; end
        chk("push_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb.size() > 0 && n < bound) begin tick(); n++; end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    // f stubbed to zero: latency, pass-through result and key/subkey order.
    task automatic run_zero(input logic dec, input logic [TAG_W-1:0] tag);
        logic [5:0] klog[$];
        logic [5:0] ek;
        int n, bad, idx, key, sub;
        logic b1;
        stub_zero = 1'b1;
        b1 = 1'b0;
        push(64'h0123456789abcdef, dec, tag);
        n = 0;
        while (!out_valid && n < 200) begin
            if (busy) klog.push_back({rnd_key_sel, rnd_sub_idx});
            if (n == 1) b1 = busy;
            tick();
            n++;
        end
        chk("zero_latency", 64'(n), 64'(1 + ROUNDS * PASSES));
        chk("zero_data", out_data, 64'h89abcdef01234567);
        chk("zero_tag", 64'({out_dec, out_tag}), 64'({dec, tag}));
        chk("busy_run", 64'(b1), 64'd1);
        chk("busy_done", 64'(busy), 64'd0);
        bad = 0; idx = 0;
        for (int p = 0; p < PASSES; p++) begin
            key = dec ? PASSES - 1 - p : p;
            for (int k = 0; k < ROUNDS; k++) begin
                sub = ((((p % 2) == 0) ^ dec) != 0) ? k : ROUNDS - 1 - k;
                ek  = {2'(key), 4'(sub)};
                if (idx >= klog.size() || klog[idx] !== ek) bad++;
                idx++;
            end
        end
        chk("keylog_len", 64'(klog.size()), 64'(ROUNDS * PASSES));
        chk("keylog_order", 64'(bad), 64'd0);
        tick();
        stub_zero = 1'b0;
    endtask

    initial begin
        logic [63:0] x;
        logic        dd;
        int          n, bad;

        n_rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_dec = 1'b0; in_tag = '0;
        out_ready = 1'b1; stub_zero = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; in_dec1 = 1'b0; in_tag1 = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_meta", 64'({out_dec, out_tag}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_rnd", 64'({rnd_r, rnd_key_sel, rnd_sub_idx}), 64'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Pass-through behaviour with f = 0, encrypt and decrypt
        run_zero(1'b0, 2'd2);
        run_zero(1'b1, 2'd1);

        // Random blocks one at a time, then a round trip each way
        for (int i = 0; i < 4; i++) begin
            push({$urandom, $urandom}, 1'($urandom), 2'($urandom));
            drain(200);
        end
        for (int i = 0; i < 2; i++) begin
            x  = {$urandom, $urandom};
            dd = 1'(i);
            push(x, dd, 2'd3);
            drain(200);
            push(last_out, ~dd, 2'd0);
            drain(200);
            chk("round_trip", last_out, x);
        end

        // Back-to-back pushes with a random consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 6; i++) push({$urandom, $urandom}, 1'($urandom), 2'($urandom));
        drain(1500);
        rand_ready = 1'b0;
        out_ready = 1'b1;

        // Back-pressure: result held, FIFO fills to DEPTH, fifth push refused
        out_ready = 1'b0;
        push({$urandom, $urandom}, 1'b0, 2'd0);
        n = 0;
        while (!out_valid && n < 200) begin tick(); n++; end
        chk("bp_held", 64'(out_valid), 64'd1);
        for (int i = 1; i <= 4; i++) push({$urandom, $urandom}, 1'($urandom), 2'(i));
        chk("bp_count", 64'(fifo_count), 64'd4);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_idle", 64'(busy), 64'd0);
        in_valid = 1'b1; in_data = 64'hdeadbeefcafef00d;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("bp_refused", 64'(fifo_count), 64'd4);
        out_times.delete();
        out_ready = 1'b1;
        drain(400);
        chk("bp_outputs", 64'(out_times.size()), 64'd5);
        bad = 0;
        for (int i = 1; i < out_times.size(); i++)
            if (out_times[i] - out_times[i-1] != 1 + ROUNDS * PASSES) bad++;
        chk("bp_spacing", 64'(bad), 64'd0);

        // Synchronous clear mid-RUN with two queued
        for (int i = 0; i < 3; i++) push({$urandom, $urandom}, 1'b0, 2'd1);
        repeat (10) tick();
        chk("pre_clear_count", 64'(fifo_count), 64'd2);
        chk("pre_clear_busy", 64'(busy), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sb.delete();
        chk("clear_state", 64'({busy, fifo_count, out_valid, in_ready}), 64'({1'b0, 3'd0, 1'b0, 1'b1}));
        push({$urandom, $urandom}, 1'b1, 2'd2);
        drain(200);

        // Asynchronous reset mid-pass
        push({$urandom, $urandom}, 1'b0, 2'd3);
        push({$urandom, $urandom}, 1'b1, 2'd0);
        repeat (20) tick();
        n_rst = 1'b0;
        #1;
        chk("arst_state", 64'({busy, fifo_count, out_valid, in_ready}), 64'({1'b0, 3'd0, 1'b0, 1'b1}));
        chk("arst_rnd", 64'({rnd_r, rnd_key_sel, rnd_sub_idx}), 64'd0);
        sb.delete();
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        push({$urandom, $urandom}, 1'b0, 2'd1);
        drain(200);

        // Single-pass unit: 17-cycle latency, encrypt and decrypt
        for (int i = 0; i < 2; i++) begin
            x = {$urandom, $urandom};
            in_valid1 = 1'b1; in_data1 = x; in_dec1 = 1'(i); in_tag1 = 2'(i + 1);
            @(negedge clk);
            in_valid1 = 1'b0;
            n = 0;
            while (!out_valid1 && n < 100) begin @(negedge clk); n++; end
            chk("p1_latency", 64'(n), 64'd17);
            chk("p1_data", out_data1, ref_block(x, 1'(i), 1, 16, 1'b0));
            chk("p1_meta", 64'({out_dec1, out_tag1}), 64'({1'(i), 2'(i + 1)}));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
